// File: rtl/alu_dec_pipe_pkg.sv
// Shared encodings for the pipelined ALU decoder: opcodes, funct fields,
// widened ALU op codes (base ops 0..15, RV32M ops 16..23) and FSM states.
package alu_dec_pipe_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_NOOP   = 7'b0001111;

  localparam logic [6:0] FNC7_BASE   = 7'b0000000;
  localparam logic [6:0] FNC7_ALT    = 7'b0100000;
  localparam logic [6:0] FNC7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_COPY_B = 5'd10,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23,
    ALU_XXX    = 5'd31
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // funct3 -> base ALU op, ignoring the SUB/SRA alternate encodings.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      F3_ADD_SUB: base_op = ALU_ADD;
      F3_SLL:     base_op = ALU_SLL;
      F3_SLT:     base_op = ALU_SLT;
      F3_SLTU:    base_op = ALU_SLTU;
      F3_XOR:     base_op = ALU_XOR;
      F3_SRL_SRA: base_op = ALU_SRL;
      F3_OR:      base_op = ALU_OR;
      default:    base_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec_comb.sv
// Purely combinational decode table: opcode/funct3/funct7 -> ALU op,
// illegal flag and multi-cycle class (multiply or divide).
module alu_dec_comb
  import alu_dec_pipe_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_e    op_o,
  output logic       illegal_o,
  output logic       is_mul_o,
  output logic       is_div_o
);

  always_comb begin
    op_o      = ALU_XXX;
    illegal_o = 1'b0;
    is_mul_o  = 1'b0;
    is_div_o  = 1'b0;
    case (opcode_i)
      OPC_LUI: op_o = ALU_COPY_B;
      OPC_AUIPC, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR: op_o = ALU_ADD;
      OPC_NOOP: op_o = ALU_XXX;
      OPC_OP: begin
        if (funct7_i == FNC7_BASE) begin
          op_o = base_op(funct3_i);
        end else if (funct7_i == FNC7_ALT && funct3_i == F3_ADD_SUB) begin
          op_o = ALU_SUB;
        end else if (funct7_i == FNC7_ALT && funct3_i == F3_SRL_SRA) begin
          op_o = ALU_SRA;
        end else if (funct7_i == FNC7_MULDIV && ENABLE_M) begin
          // M ops occupy 16..23 in funct3 order; funct3[2] splits mul from div.
          op_o     = alu_op_e'({2'b10, funct3_i});
          is_div_o = funct3_i[2];
          is_mul_o = !funct3_i[2];
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        case (funct3_i)
          F3_SLL: begin
            if (funct7_i == FNC7_BASE) op_o = ALU_SLL;
            else illegal_o = 1'b1;
          end
          F3_SRL_SRA: begin
            if (funct7_i == FNC7_BASE) op_o = ALU_SRL;
            else if (funct7_i == FNC7_ALT) op_o = ALU_SRA;
            else illegal_o = 1'b1;
          end
          default: op_o = base_op(funct3_i);
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_dec_pipe.sv
// Registered, valid/ready-handshaked ALU decoder; M ops are held for a
// fixed per-class latency before being presented to the execute stage.
module alu_dec_pipe
  import alu_dec_pipe_pkg::*;
#(
  parameter int OP_W       = 5,
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 34
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] alu_op,
  output logic            illegal,
  output logic            multi,
  output state_e          dbg_state
);

  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);

  // Handshake: a request transfers on a cycle where in_valid && in_ready, a result
  // on a cycle where out_valid && out_ready; flush blocks acceptance that cycle.

  alu_op_e   dec_op;
  logic      dec_illegal;
  logic      dec_mul;
  logic      dec_div;
  logic      accept;
  logic      long_op;
  logic [OP_W-1:0] alu_op_d;

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            out_valid_q;
  logic [OP_W-1:0] alu_op_q;
  logic            illegal_q;
  logic            multi_q;

  alu_dec_comb #(.ENABLE_M(ENABLE_M)) u_dec (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .op_o      (dec_op),
    .illegal_o (dec_illegal),
    .is_mul_o  (dec_mul),
    .is_div_o  (dec_div)
  );

  assign in_ready = !flush && ((state_q == ST_IDLE) || (state_q == ST_HOLD && out_ready));
  assign accept   = in_valid && in_ready;
  assign long_op  = (dec_mul && (MUL_CYCLES > 1)) || (dec_div && (DIV_CYCLES > 1));
  // ALU_XXX is all-ones at whatever width the op port has.
  assign alu_op_d = (dec_op == ALU_XXX) ? '1 : OP_W'(dec_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      alu_op_q    <= '1;
      illegal_q   <= 1'b0;
      multi_q     <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      alu_op_q  <= alu_op_d;
      illegal_q <= dec_illegal;
      multi_q   <= dec_mul || dec_div;
      if (long_op) begin
        state_q     <= ST_WAIT;
        cnt_q       <= dec_div ? DIV_LOAD : MUL_LOAD;
        out_valid_q <= 1'b0;
      end else begin
        state_q     <= ST_HOLD;
        out_valid_q <= 1'b1;
      end
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = alu_op_q;
  assign illegal   = illegal_q;
  assign multi     = multi_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_dec_pipe.sv
// Directed bench for alu_dec_pipe: decode table vectors plus hand-written
// handshake, latency, stall, flush and reset sequences.
module tb_alu_dec_pipe;
  import alu_dec_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] alu_op;
  logic       illegal;
  logic       multi;
  state_e     dbg_state;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] op;
    logic       ill;
    logic       mul;
    int         lat;
  } vec_t;

  vec_t vecs[$];
  logic [5:0] exp_q[$];

  alu_dec_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .illegal   (illegal),
    .multi     (multi),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver
  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    opcode   = opc;
    funct3   = f3;
    funct7   = f7;
    in_valid = 1'b1;
  endtask

  initial begin
    vec_t v;
    int   lat;
    int   ready_low;
    logic [5:0] e;

    vecs.push_back('{OPC_LUI,    3'b000, 7'h00, ALU_COPY_B, 1'b0, 1'b0, 1});
    vecs.push_back('{OPC_AUIPC,  3'b000, 7'h00, ALU_ADD,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_JAL,    3'b000, 7'h00, ALU_ADD,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_JALR,   3'b000, 7'h00, ALU_ADD,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_BRANCH, 3'b001, 7'h20, ALU_ADD,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_LOAD,   3'b010, 7'h00, ALU_ADD,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_STORE,  3'b010, 7'h00, ALU_ADD,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_NOOP,   3'b000, 7'h00, ALU_XXX,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_OP,     3'b000, 7'h00, ALU_ADD,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_OP,     3'b000, 7'h20, ALU_SUB,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_OP,     3'b101, 7'h00, ALU_SRL,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_OP,     3'b101, 7'h20, ALU_SRA,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_OP,     3'b001, 7'h20, ALU_XXX,    1'b1, 1'b0, 1});
    vecs.push_back('{OPC_OP,     3'b010, 7'h00, ALU_SLT,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_OP,     3'b011, 7'h00, ALU_SLTU,   1'b0, 1'b0, 1});
    vecs.push_back('{OPC_OP,     3'b110, 7'h00, ALU_OR,     1'b0, 1'b0, 1});
    vecs.push_back('{OPC_OP,     3'b111, 7'h00, ALU_AND,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_OP,     3'b000, 7'h02, ALU_XXX,    1'b1, 1'b0, 1});
    vecs.push_back('{OPC_OP,     3'b000, 7'h01, ALU_MUL,    1'b0, 1'b1, 2});
    vecs.push_back('{OPC_OP,     3'b011, 7'h01, ALU_MULHU,  1'b0, 1'b1, 2});
    vecs.push_back('{OPC_OP,     3'b101, 7'h01, ALU_DIVU,   1'b0, 1'b1, 34});
    vecs.push_back('{OPC_OP,     3'b111, 7'h01, ALU_REMU,   1'b0, 1'b1, 34});
    vecs.push_back('{OPC_OP_IMM, 3'b000, 7'h7F, ALU_ADD,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_OP_IMM, 3'b001, 7'h00, ALU_SLL,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_OP_IMM, 3'b001, 7'h20, ALU_XXX,    1'b1, 1'b0, 1});
    vecs.push_back('{OPC_OP_IMM, 3'b101, 7'h20, ALU_SRA,    1'b0, 1'b0, 1});
    vecs.push_back('{OPC_OP_IMM, 3'b101, 7'h01, ALU_XXX,    1'b1, 1'b0, 1});
    vecs.push_back('{OPC_OP_IMM, 3'b011, 7'h55, ALU_SLTU,   1'b0, 1'b0, 1});
    vecs.push_back('{OPC_OP_IMM, 3'b100, 7'h40, ALU_XOR,    1'b0, 1'b0, 1});
    vecs.push_back('{7'h7F,      3'b000, 7'h00, ALU_XXX,    1'b1, 1'b0, 1});
    vecs.push_back('{7'b1110011, 3'b000, 7'h00, ALU_XXX,    1'b1, 1'b0, 1});

    // reset state
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd31);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_multi", 32'(multi), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // decode table, one request at a time with out_ready=1
    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.opc, v.f3, v.f7);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
        tick();
        lat++;
      end
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v.lat));
      chk($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(v.op));
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(v.ill));
      chk($sformatf("v%0d_multi", i), 32'(multi), 32'(v.mul));
      tick();
    end

    // DIV: in_ready low 33 cycles, result exactly 34 cycles after accept
    drive(OPC_OP, 3'b100, 7'h01);
    tick();
    in_valid = 1'b0;
    lat = 1;
    ready_low = 0;
    while (!out_valid && lat < 60) begin
      if (!in_ready) ready_low++;
      tick();
      lat++;
    end
    chk("div_latency", 32'(lat), 32'd34);
    chk("div_ready_low", 32'(ready_low), 32'd33);
    chk("div_alu_op", 32'(alu_op), 32'(ALU_DIV));
    chk("div_multi", 32'(multi), 32'd1);
    tick();

    // back-to-back stream ADDI(f7=7F), SLLI(f7=0100000), opcode 0x7F
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin drive(OPC_OP_IMM, 3'b000, 7'h7F); exp_q.push_back({1'b0, 5'(ALU_ADD)}); end
        1: begin drive(OPC_OP_IMM, 3'b001, 7'h20); exp_q.push_back({1'b1, 5'(ALU_XXX)}); end
        default: begin drive(7'h7F, 3'b000, 7'h00); exp_q.push_back({1'b1, 5'(ALU_XXX)}); end
      endcase
      #1;
      chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      chk($sformatf("stream%0d_out_valid", i), 32'(out_valid), 32'd1);
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("stream%0d_result", i), 32'({illegal, alu_op}), 32'(e));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", 32'(out_valid), 32'd0);
    chk("stream_q_empty", 32'(exp_q.size()), 32'd0);

    // HOLD stall 4 cycles with XOR pending, then no-bubble handoff
    out_ready = 1'b0;
    drive(OPC_OP, 3'b111, 7'h00);
    tick();
    drive(OPC_OP, 3'b100, 7'h00);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_alu_op", k), 32'(alu_op), 32'(ALU_AND));
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("stall_xor_valid", 32'(out_valid), 32'd1);
    chk("stall_xor_op", 32'(alu_op), 32'(ALU_XOR));
    tick();

    // flush during MUL WAIT with a request pending
    drive(OPC_OP, 3'b000, 7'h01);
    tick();
    flush = 1'b1;
    drive(OPC_OP, 3'b000, 7'h00);
    #1;
    chk("flush_state_wait", 32'(dbg_state), 32'(ST_WAIT));
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    flush = 1'b0;
    #1;
    chk("post_flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("post_flush_valid", 32'(out_valid), 32'd1);
    chk("post_flush_op", 32'(alu_op), 32'(ALU_ADD));
    chk("post_flush_multi", 32'(multi), 32'd0);
    tick();

    // async reset in the middle of a DIV wait
    drive(OPC_OP, 3'b100, 7'h01);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_state", 32'(dbg_state), 32'(ST_WAIT));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mid_rst_multi", 32'(multi), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("after_rst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 40; k++) begin
      if (out_valid) break;
      tick();
    end
    chk("after_rst_no_result", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
